// File: rtl/load_unit_if.sv
// Load unit bus bundle: execute-side request, data-memory read port and
// writeback result. The load unit uses the slave view; execute, memory and
// writeback together form the master view.
//   req_valid/req_ready/instruction/addr : load request from execute
//   mem_rd_en/mem_addr/mem_rvalid/mem_rdata : data-memory read port
//   ld_valid/ld_data/ld_rd/ld_fault : completed load or fault
//   busy : unit is not idle
interface load_unit_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] instruction;
    logic [DATA_W-1:0] addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic [4:0]        ld_rd;
    logic [1:0]        ld_fault;
    logic              busy;

    modport slave (
        input  req_valid, instruction, addr, mem_rvalid, mem_rdata,
        output req_ready, mem_rd_en, mem_addr, ld_valid, ld_data, ld_rd,
               ld_fault, busy
    );

    modport master (
        output req_valid, instruction, addr, mem_rvalid, mem_rdata,
        input  req_ready, mem_rd_en, mem_addr, ld_valid, ld_data, ld_rd,
               ld_fault, busy
    );
endinterface

// File: rtl/load_unit.sv
// Data-memory read engine. Accepts a load from execute, issues one
// word-aligned read, waits (bounded by TIMEOUT) for the response, extracts
// and extends the addressed byte/halfword/word and returns it with rd.
// Illegal funct3, misalignment and timeout are reported on ld_fault.
// Ports: clk, rst (synchronous, active high), bus (load_unit_if.slave).
//
// state | meaning
// IDLE  | ready for a new load
// REQ   | one-cycle read strobe to memory, timeout counter cleared
// WAIT  | waiting for mem_rvalid or timeout
// DONE  | ld_valid pulse with result or fault
module load_unit #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    load_unit_if.slave bus
);
    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [6:0]       OP_LOAD = 7'b0000011;
    localparam logic [1:0]       F_OK    = 2'b00;
    localparam logic [1:0]       F_MIS   = 2'b01;
    localparam logic [1:0]       F_ILL   = 2'b10;
    localparam logic [1:0]       F_TO    = 2'b11;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q;
    logic [1:0]        lane_q;
    logic [4:0]        rd_q;
    logic [DATA_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] ld_data_q, ld_data_d;
    logic [4:0]        ld_rd_q, ld_rd_d;
    logic [1:0]        ld_fault_q, ld_fault_d;
    logic              capture, finish;

    logic [6:0]        opcode_in;
    logic [2:0]        f3_in;
    logic [4:0]        rd_in;
    logic              illegal_in, misaligned_in, ready;
    logic [7:0]        sel_b;
    logic [15:0]       sel_h;
    logic [DATA_W-1:0] ext;
    logic              unused_bits;

    assign opcode_in   = bus.instruction[6:0];
    assign rd_in       = bus.instruction[11:7];
    assign f3_in       = bus.instruction[14:12];
    assign unused_bits = ^bus.instruction[DATA_W-1:15];

    assign illegal_in = !(f3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    // Halfword loads (001/101) need addr[0]=0; word loads need both low bits clear.
    assign misaligned_in = ((f3_in[1:0] == 2'b01) && bus.addr[0]) ||
                           ((f3_in == 3'b010) && (bus.addr[1:0] != 2'b00));

    assign ready = (state_q == IDLE) && !rst;

    assign sel_b = bus.mem_rdata[{lane_q, 3'b000} +: 8];
    assign sel_h = bus.mem_rdata[{lane_q[1], 4'b0000} +: 16];

    always_comb begin
        ext = bus.mem_rdata;
        case (f3_q)
            3'b000:  ext = {{(DATA_W-8){sel_b[7]}}, sel_b};
            3'b100:  ext = {{(DATA_W-8){1'b0}}, sel_b};
            3'b001:  ext = {{(DATA_W-16){sel_h[15]}}, sel_h};
            3'b101:  ext = {{(DATA_W-16){1'b0}}, sel_h};
            default: ext = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        finish     = 1'b0;
        ld_data_d  = '0;
        ld_fault_d = F_OK;
        ld_rd_d    = rd_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && ready && (opcode_in == OP_LOAD)) begin
                    capture = 1'b1;
                    if (illegal_in || misaligned_in) begin
                        // Faults complete straight away; rd comes from the live request.
                        finish     = 1'b1;
                        ld_fault_d = illegal_in ? F_ILL : F_MIS;
                        ld_rd_d    = rd_in;
                        state_d    = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    finish    = 1'b1;
                    ld_data_d = ext;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == TO_VAL) begin
                        finish     = 1'b1;
                        ld_fault_d = F_TO;
                        state_d    = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            f3_q       <= '0;
            lane_q     <= '0;
            rd_q       <= '0;
            mem_addr_q <= '0;
            ld_data_q  <= '0;
            ld_rd_q    <= '0;
            ld_fault_q <= F_OK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                f3_q       <= f3_in;
                lane_q     <= bus.addr[1:0];
                rd_q       <= rd_in;
                mem_addr_q <= {bus.addr[DATA_W-1:2], 2'b00};
            end
            // Result registers only move when a load completes, so they hold between pulses.
            if (finish) begin
                ld_data_q  <= ld_data_d;
                ld_rd_q    <= ld_rd_d;
                ld_fault_q <= ld_fault_d;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.mem_rd_en = (state_q == REQ);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.ld_valid  = (state_q == DONE);
    assign bus.ld_data   = ld_data_q;
    assign bus.ld_rd     = ld_rd_q;
    assign bus.ld_fault  = ld_fault_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: doc/load_unit.md
# load_unit

Data-memory read engine for the single-cycle core, the load-side counterpart of the store formatter. It accepts a load instruction and byte address from execute, issues one word-aligned read to data memory, and waits a variable number of cycles for the response. It then extracts the addressed byte or halfword, sign- or zero-extends it per funct3, and returns a `DataBusBits`-wide writeback value with the destination register. Misaligned accesses, illegal funct3 and memory timeouts are reported as faults instead of being issued or waited on forever.

## Interface
- `DATA_W`, default `DataBusBits` (32): data and instruction width.
- `TIMEOUT`, default 255: maximum cycles spent in WAIT before a timeout fault; must be ≥1.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  execute presents a load.
- `req_ready`  out  1  unit can accept a load; high only in IDLE.
- `instruction`  in  DATA_W  instruction word; opcode [6:0], rd [11:7], funct3 [14:12].
- `addr`  in  DATA_W  effective byte address.
- `mem_rd_en`  out  1  single-cycle read strobe to data memory.
- `mem_addr`  out  DATA_W  word-aligned read address `{addr[31:2],2'b00}`, held from REQ until DONE.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  DATA_W  read word, little-endian lanes.
- `ld_valid`  out  1  one-cycle pulse: result or fault available.
- `ld_data`  out  DATA_W  extended load value; 0 when faulted.
- `ld_rd`  out  5  destination register of the completed load.
- `ld_fault`  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: a request is accepted when `req_valid & req_ready` and opcode = 7'b0000011. The unit captures funct3, addr[1:0], rd and the aligned address. A non-load opcode is ignored: the unit stays in IDLE and produces no `ld_valid`.
- Checks at accept, with illegal funct3 taking priority over misalignment:
  - funct3 not in {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU} → fault 10, next state DONE.
  - LH/LHU with addr[0]=1, or LW with addr[1:0]≠0 → fault 01, next state DONE.
  - Otherwise next state REQ.
- REQ: `mem_rd_en`=1 for exactly one cycle; clear the timeout counter; next state WAIT.
- WAIT:
  - `mem_rvalid`=1 → latch the extracted value, fault 00, next state DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT → fault 11, `ld_data`=0, next state DONE.
- DONE: `ld_valid`=1 for one cycle with `ld_data`, `ld_rd` and `ld_fault` stable; next state IDLE.
- Extraction, with lane = addr[1:0]:
  - LB: sign-extend `mem_rdata[8*lane+7 : 8*lane]`.
  - LBU: zero-extend the same byte.
  - LH: sign-extend `mem_rdata[16*addr[1]+15 : 16*addr[1]]`.
  - LHU: zero-extend the same halfword.
  - LW: pass the full word.
- `mem_rvalid` is ignored outside WAIT, including a late response after a timeout or reset.

## Timing
- Reset values: state IDLE, `mem_rd_en`=0, `mem_addr`=0, `ld_valid`=0, `ld_data`=0, `ld_rd`=0, `ld_fault`=00, `busy`=0, counter 0. `req_ready`=0 while `rst` is high and 1 from the first cycle after release.
- Normal path, with accept in cycle N: `mem_rd_en` high in N+1; WAIT from N+2; `mem_rvalid` in cycle M≥N+2 gives `ld_valid` in M+1. Minimum latency is 3 cycles.
- Fault at accept in N: `ld_valid` in N+1, and no `mem_rd_en` is ever issued.
- Timeout: with no `mem_rvalid` in WAIT cycles N+2 … N+1+TIMEOUT, `ld_valid` with fault 11 follows in the next cycle.
- Back-to-back: `req_ready` returns high in the cycle after DONE, so the next accept is possible one cycle after `ld_valid`.
- `rst` asserted in any state, mid-transaction included: return to IDLE on the next edge and drop the pending load with no `ld_valid`.
- Output registers hold their last value between pulses. `ld_valid` is the only qualifier.

## Test plan
- LB with addr=0x1003, `mem_rdata`=0x80FF_1234, rvalid 2 cycles after the strobe → `mem_addr`=0x1000, `ld_data`=0xFFFF_FF80, `ld_fault`=00, `ld_valid` 4 cycles after accept.
- LBU and LHU with addr=0x2002, `mem_rdata`=0x9ABC_5678 → LBU gives 0x0000_00BC; LHU gives 0x0000_9ABC; LH gives 0xFFFF_9ABC.
- LW with addr=0x3002 → fault 01, `ld_valid` in accept+1, `mem_rd_en` never asserted. LH with addr=0x3001 → fault 01.
- funct3=011 → fault 10. Non-load opcode 0100011 with `req_valid` → no `ld_valid`, `req_ready` stays 1.
- TIMEOUT=4 with `mem_rvalid` held low → fault 11, `ld_data`=0. A `mem_rvalid` pulse 2 cycles later is ignored and produces no second `ld_valid`.
- `rst` pulsed during WAIT, then `mem_rvalid` → no `ld_valid`, `busy`=0. A new LW at 0x0 completes normally with `ld_rd` equal to the new rd.
